// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready channels,
// with a fixed number of wait states before the response is presented.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_s;
    logic          wr_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic          ready_r;
    logic          valid_r;
    logic          err_r;
    logic [31:0]   rdata_r;
    logic [15:0]   stat_loads_r;
    logic [15:0]   stat_stores_r;
    logic [31:0]   mem_r [DEPTH];

    logic          accept_s;
    logic          commit_s;
    logic          rsp_hs_s;
    logic          cmt_write_s;
    logic [31:0]   cmt_addr_s;
    logic [31:0]   cmt_wdata_s;
    logic          in_range_s;
    logic [AW-1:0] cmt_idx_s;

    assign accept_s = ready_r && req_valid;
    assign rsp_hs_s = (state_r == ST_RESP) && rsp_ready;

    // With zero wait states the commit happens on the accepting edge, so the
    // live request fields are used instead of the latched copies.
    assign cmt_write_s = (state_r == ST_IDLE) ? req_write : wr_r;
    assign cmt_addr_s  = (state_r == ST_IDLE) ? req_addr  : addr_r;
    assign cmt_wdata_s = (state_r == ST_IDLE) ? req_wdata : wdata_r;
    assign in_range_s  = (cmt_addr_s < 32'(DEPTH));
    assign cmt_idx_s   = cmt_addr_s[AW-1:0];

    // Next-state, wait counter and commit strobe.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        commit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_s = WAIT_LOAD;
                    if (ZERO_WAIT) begin
                        state_s  = ST_RESP;
                        commit_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_s  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control state, request latch, response registers and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            wr_r          <= 1'b0;
            addr_r        <= 32'd0;
            wdata_r       <= 32'd0;
            ready_r       <= 1'b0;
            valid_r       <= 1'b0;
            err_r         <= 1'b0;
            rdata_r       <= 32'd0;
            stat_loads_r  <= 16'd0;
            stat_stores_r <= 16'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == ST_IDLE);
            valid_r <= (state_s == ST_RESP);
            if (accept_s) begin
                wr_r    <= req_write;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            if (commit_s) begin
                err_r   <= !in_range_s;
                rdata_r <= (in_range_s && !cmt_write_s) ? mem_r[cmt_idx_s] : 32'd0;
            end
            if (rsp_hs_s) begin
                if (wr_r) begin
                    if (stat_stores_r != 16'hFFFF) begin
                        stat_stores_r <= stat_stores_r + 16'd1;
                    end
                end else begin
                    if (stat_loads_r != 16'hFFFF) begin
                        stat_loads_r <= stat_loads_r + 16'd1;
                    end
                end
            end
        end
    end

    // Storage array; deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (commit_s && in_range_s && cmt_write_s) begin
            mem_r[cmt_idx_s] <= cmt_wdata_s;
        end
    end

    assign req_ready   = ready_r;
    assign rsp_valid   = valid_r;
    assign rsp_rdata   = rdata_r;
    assign rsp_err     = err_r;
    assign stat_loads  = stat_loads_r;
    assign stat_stores = stat_stores_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) driven by
// directed and random transactions against a behavioural memory model.
module tb_dmem_responder;
    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic        req_write   [2];
    logic [31:0] req_addr    [2];
    logic [31:0] req_wdata   [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic [31:0] rsp_rdata   [2];
    logic        rsp_err     [2];
    logic [15:0] stat_loads  [2];
    logic [15:0] stat_stores [2];

    int          n_cmp;
    int          n_err;
    int          cyc;
    int          last_acc [2];
    logic [31:0] mdl_mem  [2][DEPTH];
    bit          mdl_wrt  [2][DEPTH];
    int          mdl_ld   [2];
    int          mdl_st   [2];

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .stat_loads(stat_loads[0]), .stat_stores(stat_stores[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .stat_loads(stat_loads[1]), .stat_stores(stat_stores[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One complete transaction on instance s, entered and left at a negedge.
    // bp = cycles of rsp_ready low after rsp_valid; 0 means rsp_ready is high early.
    task automatic txn(input int s, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input int bp, input bit chk_rate);
        int          n;
        int          w;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [31:0] held;
        w            = (s == 0) ? 2 : 0;
        req_write[s] = wr;
        req_addr[s]  = addr;
        req_wdata[s] = wd;
        req_valid[s] = 1'b1;
        rsp_ready[s] = (bp == 0);
        n = 0;
        while (!req_ready[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_wait", 32'(n < 50), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (chk_rate) check_eq("accept_spacing", 32'(cyc - last_acc[s]), 32'(w + 2));
        last_acc[s] = cyc;
        if (bp == 0) req_valid[s] = 1'b0;
        check_eq("ready_low_busy", 32'(req_ready[s]), 32'd0);

        // Spec-level expectation for this access.
        exp_err = (addr >= 32'(DEPTH));
        exp_rd  = (!exp_err && !wr) ? mdl_mem[s][addr[7:0]] : 32'd0;
        if (!exp_err && wr) begin
            mdl_mem[s][addr[7:0]] = wd;
            mdl_wrt[s][addr[7:0]] = 1'b1;
        end

        n = 1;
        while (!rsp_valid[s] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("latency", 32'(n), 32'(w + 1));
        check_eq("rsp_rdata", rsp_rdata[s], exp_rd);
        check_eq("rsp_err", 32'(rsp_err[s]), 32'(exp_err));
        held = rsp_rdata[s];
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(rsp_valid[s]), 32'd1);
            check_eq("bp_rdata", rsp_rdata[s], held);
            check_eq("bp_ready", 32'(req_ready[s]), 32'd0);
        end
        if (bp > 0) begin
            req_valid[s] = 1'b0;
            rsp_ready[s] = 1'b1;
        end
        @(negedge clk);
        if (wr) mdl_st[s] = (mdl_st[s] < 65535) ? mdl_st[s] + 1 : 65535;
        else    mdl_ld[s] = (mdl_ld[s] < 65535) ? mdl_ld[s] + 1 : 65535;
        check_eq("rsp_valid_drop", 32'(rsp_valid[s]), 32'd0);
        check_eq("ready_back", 32'(req_ready[s]), 32'd1);
        check_eq("stat_loads", 32'(stat_loads[s]), 32'(mdl_ld[s]));
        check_eq("stat_stores", 32'(stat_stores[s]), 32'(mdl_st[s]));
    endtask

    initial begin
        int          s;
        int          a;
        bit          wr;
        logic [31:0] addr;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'd0;
            req_wdata[i] = 32'd0; rsp_ready[i] = 1'b0;
            mdl_ld[i] = 0; mdl_st[i] = 0; last_acc[i] = 0;
            for (int j = 0; j < DEPTH; j++) mdl_wrt[i][j] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_req_ready", 32'(req_ready[i]), 32'd0);
            check_eq("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check_eq("rst_rsp_rdata", rsp_rdata[i], 32'd0);
            check_eq("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
            check_eq("rst_stat_loads", 32'(stat_loads[i]), 32'd0);
            check_eq("rst_stat_stores", 32'(stat_stores[i]), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(req_ready[0]), 32'd1);

        // Store then load, plus out-of-range and aliasing checks.
        txn(0, 1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0);
        txn(0, 1'b0, 32'd5, 32'd0, 0, 1'b0);
        txn(0, 1'b1, 32'd0, 32'h0, 0, 1'b0);
        txn(0, 1'b1, 32'd256, 32'h12345678, 0, 1'b0);
        txn(0, 1'b0, 32'd0, 32'd0, 0, 1'b0);
        txn(0, 1'b0, 32'hFFFFFFFF, 32'd0, 0, 1'b0);

        // Backpressure with a second request held during it.
        txn(0, 1'b1, 32'd3, 32'h55, 0, 1'b0);
        txn(0, 1'b0, 32'd3, 32'd0, 5, 1'b0);

        // Reset during WAIT drops an in-flight store.
        txn(0, 1'b1, 32'd7, 32'h1111, 0, 1'b0);
        req_write[0] = 1'b1; req_addr[0] = 32'd7; req_wdata[0] = 32'hAAAA;
        req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(rsp_valid[0]), 32'd0);
        check_eq("midrst_loads", 32'(stat_loads[0]), 32'd0);
        check_eq("midrst_stores", 32'(stat_stores[0]), 32'd0);
        check_eq("midrst_ready", 32'(req_ready[0]), 32'd0);
        for (int i = 0; i < 2; i++) begin
            mdl_ld[i] = 0;
            mdl_st[i] = 0;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("postrst_valid", 32'(rsp_valid[0]), 32'd0);
        txn(0, 1'b0, 32'd7, 32'd0, 0, 1'b0);

        // Zero wait states: back-to-back stores then loads, one per 2 cycles.
        for (int i = 0; i < 4; i++) txn(1, 1'b1, 32'(i), 32'(i + 1), 0, i > 0);
        for (int i = 0; i < 4; i++) txn(1, 1'b0, 32'(i), 32'd0, 0, 1'b1);

        // Randomized traffic on both instances.
        for (int k = 0; k < 160; k++) begin
            s  = int'($urandom_range(1, 0));
            wr = $urandom_range(1, 0) == 1;
            a  = int'($urandom_range(15, 0));
            case ($urandom_range(7, 0))
                0:       addr = 32'd256 + 32'($urandom_range(1000, 0));
                1:       addr = 32'hFFFFFFFF - 32'($urandom_range(3, 0));
                default: addr = 32'(a);
            endcase
            if (!wr && addr < 32'(DEPTH) && !mdl_wrt[s][addr[7:0]]) wr = 1'b1;
            txn(s, wr, addr, $urandom, int'($urandom_range(3, 0)), 1'b0);
        end

        // Saturation: preload the load counter near the top.
        @(negedge clk);
        force dut0.stat_loads_r = 16'hFFFD;
        @(negedge clk);
        release dut0.stat_loads_r;
        mdl_ld[0] = 65533;
        @(negedge clk);
        check_eq("sat_preload", 32'(stat_loads[0]), 32'h0000FFFD);
        for (int i = 0; i < 4; i++) txn(0, 1'b0, 32'd5, 32'd0, 0, 1'b0);
        check_eq("sat_hold", 32'(stat_loads[0]), 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
